// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Contents:
//   state_t    FSM encoding (IDLE, RUN, DONE)
//   DEF_WIDTH  default operand width
//   cnt_w_of   bit-counter width for a given operand width (WIDTH >= 2)
//   CNT_W      bit-counter width for the default operand width
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w_of(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_w_of(DEF_WIDTH);

endpackage

// File: rtl/fs_bit_cell.sv
// rtl/fs_bit_cell.sv - single-bit combinational full-subtractor cell
//
// Ports:
//   a   in   minuend bit
//   b   in   subtrahend bit
//   c   in   borrow into this bit
//   d   out  difference bit, a - b - c
//   bo  out  borrow out of this bit
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ c;
    assign bo = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin subtractor, LSB first, valid/ready on both sides
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand set a/b/bin valid
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   minuend
//   b          in   subtrahend
//   bin        in   borrow into bit 0
//   out_valid  out  diff/bout/ovf valid (DONE only)
//   out_ready  in   consumer takes the result
//   diff       out  a - b - bin modulo 2^WIDTH
//   bout       out  borrow out of the MSB
//   ovf        out  signed overflow
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_w_of(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_PREV = CW'(WIDTH - 2);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             borrow_q;
    logic             msb_bin;
    logic [WIDTH-1:0] diff_hold;
    logic             bout_hold;
    logic             ovf_hold;
    logic             cell_d;
    logic             cell_bo;

    fs_bit_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (cnt == LAST_BIT) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            diff_sh   <= '0;
            borrow_q  <= 1'b0;
            msb_bin   <= 1'b0;
            diff_hold <= '0;
            bout_hold <= 1'b0;
            ovf_hold  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        borrow_q <= bin;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    diff_sh  <= {cell_d, diff_sh[WIDTH-1:1]};
                    borrow_q <= cell_bo;
                    // Borrow out of bit WIDTH-2 is the borrow into the MSB.
                    if (cnt == MSB_PREV) msb_bin <= cell_bo;
                    if (cnt == LAST_BIT) cnt <= '0;
                    else                 cnt <= cnt + 1'b1;
                end
                DONE: begin
                    // Shadow copies keep the result visible after the handshake.
                    diff_hold <= diff_sh;
                    bout_hold <= borrow_q;
                    ovf_hold  <= msb_bin ^ borrow_q;
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registers, never on in_valid/out_ready.
    always_comb begin
        if (state == DONE) begin
            diff = diff_sh;
            bout = borrow_q;
            ovf  = msb_bin ^ borrow_q;
        end else begin
            diff = diff_hold;
            bout = bout_hold;
            ovf  = ovf_hold;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    localparam int NOPS = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic [7:0] corners [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        exp_t e;
        int   su;
        int   ss;
        su   = int'(av) - int'(bv) - int'(bi);
        ss   = int'($signed(av)) - int'($signed(bv)) - int'(bi);
        e.d  = su[7:0];
        e.bo = (su < 0);
        e.ov = (ss < -128) || (ss > 127);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_diff"}, 32'(diff), 32'(e.d));
            chk({tag, "_bout"}, 32'(bout), 32'(e.bo));
            chk({tag, "_ovf"},  32'(ovf),  32'(e.ov));
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         input string tag, input bit release_out);
        int t0;
        int k;
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        sb.push_back(model(av, bv, bi));
        step();
        in_valid = 1'b0;
        t0 = cyc;
        k  = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, 32'(cyc - t0), 32'd8);
        pop_check(tag);
        if (release_out) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic set_ops(input int n);
        logic [9:0] nn;
        nn = 10'(n);
        if (n < 128) begin
            a   = corners[nn[2:0]];
            b   = corners[nn[5:3]];
            bin = nn[6];
        end else begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            bin = nn[0];
        end
    endtask

    initial begin
        int  n;
        int  last_acc;
        int  guard;
        bit  acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        step();
        step();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_bout",      32'(bout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        step();

        do_op(8'h05, 8'h03, 1'b0, "v05_03", 1'b1);
        do_op(8'h03, 8'h05, 1'b0, "v03_05", 1'b1);
        do_op(8'h00, 8'h00, 1'b1, "v00_00_b", 1'b1);
        do_op(8'h80, 8'h01, 1'b0, "v80_01", 1'b1);
        do_op(8'h7F, 8'hFF, 1'b0, "v7F_FF", 1'b1);

        // Backpressure: result held for 5 cycles while new operands are offered.
        do_op(8'h80, 8'h01, 1'b0, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            a        = 8'h55;
            b        = 8'h22;
            in_valid = i[0];
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_diff",      32'(diff),      32'h7F);
            chk("bp_ovf",       32'(ovf),       32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_hs_in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        chk("bp_after_out_valid", 32'(out_valid), 32'd0);
        chk("bp_after_in_ready",  32'(in_ready),  32'd1);
        chk("bp_after_diff_hold", 32'(diff),      32'h7F);
        step();
        chk("bp_no_queue", 32'(out_valid), 32'd0);

        // Reset while RUN is on bit 4: operation is abandoned.
        a        = 8'h33;
        b        = 8'h44;
        bin      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_diff",      32'(diff),      32'd0);
        chk("mid_rst_bout",      32'(bout),      32'd0);
        chk("mid_rst_ovf",       32'(ovf),       32'd0);
        repeat (10) step();
        chk("mid_rst_no_result", 32'(out_valid), 32'd0);
        do_op(8'h10, 8'h01, 1'b0, "after_rst", 1'b1);

        // Back-to-back stream with in_valid held high and out_ready=1.
        out_ready = 1'b1;
        n         = 0;
        last_acc  = -1;
        guard     = 0;
        set_ops(0);
        in_valid = 1'b1;
        while ((n < NOPS || sb.size() > 0) && guard < 30000) begin
            acc = in_ready && in_valid;
            step();
            guard++;
            if (acc) begin
                sb.push_back(model(a, b, bin));
                if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                n++;
                if (n < NOPS) set_ops(n);
                else          in_valid = 1'b0;
            end
            if (out_valid === 1'b1) pop_check("b2b");
        end
        chk("b2b_ops_done", 32'(n), 32'(NOPS));
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
